// File: rtl/sdram_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sdram_arb_pkg
//  Description : Shared types for the two-master SDRAM port arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
package sdram_arb_pkg;

    // Arbiter state: idle (free to pick) or busy (grant locked on a stall)
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_t;

    // Identifies which master issued a command / owns a read beat
    typedef logic master_id_t;

    localparam master_id_t ID_M0 = 1'b0;
    localparam master_id_t ID_M1 = 1'b1;

    // Default depth of the outstanding-read tracker
    localparam int MAX_PEND_DEFAULT = 8;

endpackage
`default_nettype wire

// File: rtl/sdram_arb_id_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sdram_arb_id_fifo
//  Description : 1-bit-wide master-ID FIFO recording the issuer of every
//                accepted read so returning beats can be steered back.
//  Revision    : 1.0  initial release
// ============================================================================
module sdram_arb_id_fifo
    import sdram_arb_pkg::*;
#(
    parameter int DEPTH = MAX_PEND_DEFAULT
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          push,
    input  master_id_t                    push_id,
    input  logic                          pop,
    output master_id_t                    head_id,
    output logic [$clog2(DEPTH):0]        count,
    output logic                          full,
    output logic                          empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    master_id_t         r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               w_push;
    logic               w_pop;

    // Overflow/underflow guards: ignore a push when full, a pop when empty
    assign full    = (r_count == CNT_W'(DEPTH));
    assign empty   = (r_count == '0);
    assign w_push  = push & ~full;
    assign w_pop   = pop & ~empty;
    assign head_id = r_mem[r_rd_ptr];
    assign count   = r_count;

    // Storage array; contents need no reset since the count gates reads
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_id;
        end
    end

    // Pointers wrap naturally (DEPTH is a power of two); count tracks occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

endmodule
`default_nettype wire

// File: rtl/sdram_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : sdram_port_arbiter
//  Description : Round-robin Avalon-MM arbiter sharing one SDRAM controller
//                slave between two masters, with pipelined-read steering.
//  Revision    : 1.0  initial release
// ============================================================================
module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int ADDR_W   = 24,
    parameter int DATA_W   = 16,
    parameter int MAX_PEND = MAX_PEND_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_W-1:0]     m0_address,
    input  logic                  m0_read,
    input  logic                  m0_write,
    input  logic [DATA_W-1:0]     m0_writedata,
    input  logic [DATA_W/8-1:0]   m0_byteenable,
    output logic                  m0_waitrequest,
    output logic [DATA_W-1:0]     m0_readdata,
    output logic                  m0_readdatavalid,
    input  logic [ADDR_W-1:0]     m1_address,
    input  logic                  m1_read,
    input  logic                  m1_write,
    input  logic [DATA_W-1:0]     m1_writedata,
    input  logic [DATA_W/8-1:0]   m1_byteenable,
    output logic                  m1_waitrequest,
    output logic [DATA_W-1:0]     m1_readdata,
    output logic                  m1_readdatavalid,
    output logic [ADDR_W-1:0]     s_address,
    output logic                  s_read,
    output logic                  s_write,
    output logic [DATA_W-1:0]     s_writedata,
    output logic [DATA_W/8-1:0]   s_byteenable,
    input  logic                  s_waitrequest,
    input  logic [DATA_W-1:0]     s_readdata,
    input  logic                  s_readdatavalid
);

    localparam int CNT_W = $clog2(MAX_PEND) + 1;

    arb_state_t         r_state;
    master_id_t         r_grant;
    master_id_t         r_prefer;
    master_id_t         w_sel;
    logic               w_active;
    logic               w_req0, w_req1;
    logic               w_elig0, w_elig1;
    logic               w_sel_read, w_sel_write;
    logic               w_accept;
    logic               w_full, w_empty;
    master_id_t         w_head_id;
    logic [CNT_W-1:0]   w_count;
    logic               w_beat;

    // A read-only request (write wins when both are set) is blocked while the
    // tracker is full; the full flag comes from the registered count.
    assign w_req0  = m0_read | m0_write;
    assign w_req1  = m1_read | m1_write;
    assign w_elig0 = w_req0 & ~(m0_read & ~m0_write & w_full);
    assign w_elig1 = w_req1 & ~(m1_read & ~m1_write & w_full);

    // Grant selection: locked master while busy, otherwise round-robin
    always_comb begin
        w_sel    = r_prefer;
        w_active = 1'b0;
        if (r_state == ST_BUSY) begin
            w_sel    = r_grant;
            w_active = (r_grant == ID_M1) ? w_req1 : w_req0;
        end else if (w_elig0 && w_elig1) begin
            w_sel    = r_prefer;
            w_active = 1'b1;
        end else if (w_elig0) begin
            w_sel    = ID_M0;
            w_active = 1'b1;
        end else if (w_elig1) begin
            w_sel    = ID_M1;
            w_active = 1'b1;
        end
    end

    // Zero-latency command mux towards the slave
    assign w_sel_read   = (w_sel == ID_M1) ? m1_read  : m0_read;
    assign w_sel_write  = (w_sel == ID_M1) ? m1_write : m0_write;
    assign s_address    = (w_sel == ID_M1) ? m1_address    : m0_address;
    assign s_writedata  = (w_sel == ID_M1) ? m1_writedata  : m0_writedata;
    assign s_byteenable = (w_sel == ID_M1) ? m1_byteenable : m0_byteenable;
    assign s_write      = ~reset & w_active & w_sel_write;
    assign s_read       = ~reset & w_active & w_sel_read & ~w_sel_write;
    assign w_accept     = (s_read | s_write) & ~s_waitrequest;

    assign m0_waitrequest = reset | ~(w_active & (w_sel == ID_M0)) | s_waitrequest;
    assign m1_waitrequest = reset | ~(w_active & (w_sel == ID_M1)) | s_waitrequest;

    // Read return steering: the FIFO head names the owner of each beat
    assign w_beat           = ~reset & s_readdatavalid & ~w_empty;
    assign m0_readdatavalid = w_beat & (w_head_id == ID_M0);
    assign m1_readdatavalid = w_beat & (w_head_id == ID_M1);
    assign m0_readdata      = s_readdata;
    assign m1_readdata      = s_readdata;

    sdram_arb_id_fifo #(
        .DEPTH   (MAX_PEND)
    ) u_id_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (w_accept & s_read),
        .push_id (w_sel),
        .pop     (w_beat),
        .head_id (w_head_id),
        .count   (w_count),
        .full    (w_full),
        .empty   (w_empty)
    );

    // Grant FSM: lock on a stalled command, flip the RR pointer on acceptance
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_grant  <= ID_M0;
            r_prefer <= ID_M0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (s_read | s_write) begin
                        if (s_waitrequest) begin
                            r_state <= ST_BUSY;
                            r_grant <= w_sel;
                        end else begin
                            r_prefer <= ~w_sel;
                        end
                    end
                end
                ST_BUSY: begin
                    if (w_accept) begin
                        r_state  <= ST_IDLE;
                        r_prefer <= ~r_grant;
                    end else if (!(s_read | s_write)) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifndef SYNTHESIS
    // Protocol checks on the master and slave sides
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(m0_read && m0_write)) else $error("m0 issued read and write together");
            assert (!(m1_read && m1_write)) else $error("m1 issued read and write together");
            assert (!(s_readdatavalid && w_empty)) else $error("readdatavalid with no read outstanding");
            assert (w_count <= CNT_W'(MAX_PEND)) else $error("pending-read count out of range");
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_sdram_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sdram_port_arbiter
//  Description : Self-checking bench for sdram_port_arbiter: directed
//                scenarios followed by randomized traffic, all compared
//                against a transaction-level reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sdram_port_arbiter;

    localparam int MAX_PEND = 8;

    typedef struct packed {
        logic        id;
        logic [23:0] addr;
    } pend_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        m_rd   [2];
    logic        m_wr   [2];
    logic [23:0] m_addr [2];
    logic [15:0] m_wd   [2];
    logic [1:0]  m_be   [2];
    logic        m0_wait, m1_wait, m0_rdv, m1_rdv;
    logic [15:0] m0_rdata, m1_rdata;
    logic [23:0] s_address;
    logic        s_read, s_write;
    logic [15:0] s_writedata;
    logic [1:0]  s_byteenable;
    logic        s_wait, s_rdv;
    logic [15:0] s_rdata;

    // Reference model state
    pend_t pend[$];
    int    locked;      // -1 none, else master holding the port
    int    last;        // master served most recently
    int    mode [2];    // 0 single command, 1 read stream, 2 random
    int    left [2];
    int    slave_mode;  // 0 manual, 1 no stall + eager returns, 2 random
    int    n_tests;
    int    n_fail;

    always #5 clk = ~clk;

    sdram_port_arbiter #(
        .ADDR_W           (24),
        .DATA_W           (16),
        .MAX_PEND         (MAX_PEND)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .m0_address       (m_addr[0]),
        .m0_read          (m_rd[0]),
        .m0_write         (m_wr[0]),
        .m0_writedata     (m_wd[0]),
        .m0_byteenable    (m_be[0]),
        .m0_waitrequest   (m0_wait),
        .m0_readdata      (m0_rdata),
        .m0_readdatavalid (m0_rdv),
        .m1_address       (m_addr[1]),
        .m1_read          (m_rd[1]),
        .m1_write         (m_wr[1]),
        .m1_writedata     (m_wd[1]),
        .m1_byteenable    (m_be[1]),
        .m1_waitrequest   (m1_wait),
        .m1_readdata      (m1_rdata),
        .m1_readdatavalid (m1_rdv),
        .s_address        (s_address),
        .s_read           (s_read),
        .s_write          (s_write),
        .s_writedata      (s_writedata),
        .s_byteenable     (s_byteenable),
        .s_waitrequest    (s_wait),
        .s_readdata       (s_rdata),
        .s_readdatavalid  (s_rdv)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic new_cmd(input int i);
        int r;
        r         = $urandom_range(0, 3);
        m_addr[i] = 24'($urandom);
        m_wd[i]   = 16'($urandom);
        m_be[i]   = 2'($urandom_range(1, 3));
        m_rd[i]   = (r == 1) || (r == 2);
        m_wr[i]   = (r == 3);
    endtask

    // One clock: drive slave, check outputs against the model, advance
    task automatic step();
        logic req [2];
        logic rdo [2];
        logic el  [2];
        logic full, act, sel, e_sr, e_sw, acc;
        logic [15:0] tag_data;
        if (slave_mode == 1) begin
            s_wait = 1'b0;
            s_rdv  = (pend.size() > 0);
        end else if (slave_mode == 2) begin
            s_wait = ($urandom_range(0, 3) == 0);
            s_rdv  = (pend.size() > 0) && ($urandom_range(0, 1) == 1);
        end
        tag_data = (pend.size() > 0) ? (16'hA000 + {4'h0, pend[0].addr[11:0]}) : 16'h0000;
        s_rdata  = tag_data;
        #2;
        if (reset) begin
            chk("rst_s_read", 32'(s_read), 32'd0);
            chk("rst_s_write", 32'(s_write), 32'd0);
            chk("rst_m0_wait", 32'(m0_wait), 32'd1);
            chk("rst_m1_wait", 32'(m1_wait), 32'd1);
            chk("rst_m0_rdv", 32'(m0_rdv), 32'd0);
            chk("rst_m1_rdv", 32'(m1_rdv), 32'd0);
            @(posedge clk);
            pend.delete();
            locked = -1;
            last   = 1;
            #1;
            return;
        end
        full = (pend.size() >= MAX_PEND);
        for (int i = 0; i < 2; i++) begin
            req[i] = m_rd[i] | m_wr[i];
            rdo[i] = m_rd[i] & ~m_wr[i];
            el[i]  = req[i] && !(rdo[i] && full);
        end
        act = 1'b0;
        sel = 1'b0;
        if (locked >= 0) begin
            sel = (locked == 1);
            act = req[sel];
        end else if (el[0] && el[1]) begin
            sel = (last == 0);
            act = 1'b1;
        end else if (el[0]) begin
            sel = 1'b0;
            act = 1'b1;
        end else if (el[1]) begin
            sel = 1'b1;
            act = 1'b1;
        end
        e_sw = act && m_wr[sel];
        e_sr = act && rdo[sel];
        chk("s_read", 32'(s_read), 32'(e_sr));
        chk("s_write", 32'(s_write), 32'(e_sw));
        chk("m0_wait", 32'(m0_wait), 32'(!(act && sel == 1'b0) || s_wait));
        chk("m1_wait", 32'(m1_wait), 32'(!(act && sel == 1'b1) || s_wait));
        chk("m0_rdv", 32'(m0_rdv), 32'(s_rdv && pend.size() > 0 && pend[0].id == 1'b0));
        chk("m1_rdv", 32'(m1_rdv), 32'(s_rdv && pend.size() > 0 && pend[0].id == 1'b1));
        if (act) chk("s_address", 32'(s_address), 32'(m_addr[sel]));
        if (e_sw) begin
            chk("s_writedata", 32'(s_writedata), 32'(m_wd[sel]));
            chk("s_byteenable", 32'(s_byteenable), 32'(m_be[sel]));
        end
        if (s_rdv && pend.size() > 0) begin
            if (pend[0].id == 1'b0) chk("m0_readdata", 32'(m0_rdata), 32'(tag_data));
            else                    chk("m1_readdata", 32'(m1_rdata), 32'(tag_data));
        end
        acc = (e_sr || e_sw) && !s_wait;
        @(posedge clk);
        if (s_rdv && pend.size() > 0) void'(pend.pop_front());
        if (acc) begin
            if (e_sr) pend.push_back(pend_t'{id: sel, addr: m_addr[sel]});
            locked = -1;
            last   = sel ? 1 : 0;
        end else if (e_sr || e_sw) begin
            locked = sel ? 1 : 0;
        end else begin
            locked = -1;
        end
        #1;
        for (int i = 0; i < 2; i++) begin
            if (acc && (sel == 1'(i))) begin
                if (mode[i] == 1 && left[i] > 0) begin
                    left[i]--;
                    m_addr[i] = m_addr[i] + 24'd1;
                end else if (mode[i] == 2) begin
                    new_cmd(i);
                end else begin
                    m_rd[i] = 1'b0;
                    m_wr[i] = 1'b0;
                end
            end else if (mode[i] == 2 && !req[i]) begin
                new_cmd(i);
            end
        end
    endtask

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        locked     = -1;
        last       = 1;
        slave_mode = 0;
        for (int i = 0; i < 2; i++) begin
            m_rd[i] = 1'b0; m_wr[i] = 1'b0; m_addr[i] = '0;
            m_wd[i] = '0;   m_be[i] = 2'b11; mode[i] = 0; left[i] = 0;
        end
        s_wait = 1'b0;
        s_rdv  = 1'b1;
        s_rdata = '0;

        // Reset: strobes low, waitrequests high, no beats even if one arrives
        reset = 1'b1;
        m_wr[0] = 1'b1;
        step();
        step();
        reset = 1'b0;
        s_rdv = 1'b0;
        m_wr[0] = 1'b0;
        step();

        // Single m0 write, no stall
        m_wr[0] = 1'b1; m_addr[0] = 24'h000010; m_wd[0] = 16'hBEEF; m_be[0] = 2'b11;
        step();

        // Continuous reads from both masters, slave never stalls
        slave_mode = 1;
        mode[0] = 1; m_rd[0] = 1'b1; m_addr[0] = 24'h000100; left[0] = 5;
        mode[1] = 1; m_rd[1] = 1'b1; m_addr[1] = 24'h000200; left[1] = 5;
        repeat (14) step();
        slave_mode = 0; mode[0] = 0; mode[1] = 0;
        s_wait = 1'b0; s_rdv = 1'b0;

        // m1 read stalled 3 cycles while m0 waits; m0 goes next
        m_wr[0] = 1'b1; m_addr[0] = 24'h000020;
        step();
        m_rd[1] = 1'b1; m_addr[1] = 24'h000300;
        m_rd[0] = 1'b1; m_addr[0] = 24'h000301;
        s_wait = 1'b1;
        repeat (3) step();
        s_wait = 1'b0;
        step();
        step();
        slave_mode = 1;
        repeat (3) step();
        slave_mode = 0; s_rdv = 1'b0;

        // Nine m0 reads with no returns: eighth fills the tracker
        mode[0] = 1; m_rd[0] = 1'b1; m_addr[0] = 24'h000400; left[0] = 8;
        repeat (10) step();
        m_wr[1] = 1'b1; m_addr[1] = 24'h000500; m_wd[1] = 16'h1234; m_be[1] = 2'b01;
        step();
        step();
        s_rdv = 1'b1;
        step();
        s_rdv = 1'b0;
        step();
        slave_mode = 1;
        repeat (10) step();
        slave_mode = 0; s_rdv = 1'b0;

        // Reset with five reads outstanding
        m_rd[0] = 1'b1; m_addr[0] = 24'h000600; left[0] = 4;
        repeat (5) step();
        mode[0] = 0;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
        m_rd[1] = 1'b1; m_addr[1] = 24'h000700;
        step();
        s_rdv = 1'b1;
        step();
        s_rdv = 1'b0;

        // Push and pop in the same cycle with three m1 reads pending
        mode[1] = 1; m_rd[1] = 1'b1; m_addr[1] = 24'h000800; left[1] = 2;
        repeat (3) step();
        mode[1] = 0;
        m_rd[0] = 1'b1; m_addr[0] = 24'h000900;
        s_rdv = 1'b1;
        step();
        s_rdv = 1'b0;
        step();
        slave_mode = 1;
        repeat (5) step();

        // Randomized traffic with random stalls and returns
        slave_mode = 2;
        mode[0] = 2; mode[1] = 2;
        new_cmd(0);
        new_cmd(1);
        repeat (400) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
